hub75_rx: RTL

Receiving end of the HUB75 panel link: samples the panel-side signals (RGB0/RGB1, screen clock, latch, nOE, ABCDE), rebuilds each shifted row the way a panel's column shift registers would, and on every latch commits both half-rows to a frame-buffer write port. It serves as an in-fabric loopback monitor for the GPU's HUB75 output path and as a panel emulator for bench and on-board self-check.

---
 rtl/hub75_pkg.sv | 21 ++
 rtl/hub75_rx_if.sv | 18 +
 rtl/hub75_edge_sync.sv | 42 ++++
 rtl/hub75_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared constants, types and helpers for the HUB75 receiver.
package hub75_pkg;

    localparam int unsigned COLS_DEF     = 64;
    localparam int unsigned ROW_BITS_DEF = 5;

    localparam logic HALF_TOP    = 1'b0;
    localparam logic HALF_BOTTOM = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    // Frame-buffer address is {half, row, col}.
    function automatic int unsigned wr_addr_width(input int unsigned cols,
                                                  input int unsigned row_bits);
        return 1 + row_bits + $clog2(cols);
    endfunction

endpackage

// File: rtl/hub75_rx_if.sv
// Frame-buffer write port driven by the HUB75 receiver.
interface hub75_rx_if #(
    parameter int unsigned COLS     = hub75_pkg::COLS_DEF,
    parameter int unsigned ROW_BITS = hub75_pkg::ROW_BITS_DEF
);
    import hub75_pkg::*;

    localparam int unsigned AW = wr_addr_width(COLS, ROW_BITS);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          row_done;

    modport master (output wr_en, wr_addr, wr_data, row_done);
    modport slave  (input  wr_en, wr_addr, wr_data, row_done);

endinterface

// File: rtl/hub75_edge_sync.sv
// Multi-stage input synchronizer with optional rising-edge detection.
module hub75_edge_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2,
    parameter bit          EDGE   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise_c
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

    generate
        if (EDGE) begin : g_edge
            logic [WIDTH-1:0] prev;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) prev <= '0;
                else     prev <= q;
            end

            assign rise_c = q & ~prev;
        end else begin : g_no_edge
            assign rise_c = '0;
        end
    endgenerate

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: rebuilds shifted rows and commits them to a frame buffer on latch.
// Optional statistics counters are enabled with HUB75_RX_STATS_EN.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int unsigned COLS        = COLS_DEF,
    parameter int unsigned ROW_BITS    = ROW_BITS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          in_RGB0,
    input  logic [2:0]          in_RGB1,
    input  logic                in_SCREEN_CLOCK,
    input  logic [ROW_BITS-1:0] in_ABCDE,
    input  logic                in_LATCH,
    input  logic                in_nOE,
    hub75_rx_if.master          fb,
    output logic                out_BUSY,
    output logic                out_LIT,
    output logic                out_LEN_ERR,
    output logic                out_OVERRUN
`ifdef HUB75_RX_STATS_EN
    ,
    output logic [15:0]         out_LATCH_CNT,
    output logic [7:0]          out_LEN_ERR_CNT,
    output logic [7:0]          out_OVERRUN_CNT
`endif
);

    localparam int unsigned CB    = $clog2(COLS);
    localparam int unsigned CNT_W = $clog2(COLS + 2);
    localparam int unsigned IDX_W = $clog2(2 * COLS);
    localparam int unsigned DW    = 3 + 3 + ROW_BITS + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(2 * COLS - 1);

    logic [1:0]          unused_ctl_q;
    logic [1:0]          ctl_rise;
    logic [DW-1:0]       data_s;
    logic [DW-1:0]       unused_data_rise;
    logic                sclk_rise, latch_rise;
    logic [2:0]          rgb0_s, rgb1_s;
    logic [ROW_BITS-1:0] abcde_s;
    logic                noe_s;

    hub75_edge_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .EDGE(1'b1)) u_ctl_sync (
        .clk    (clk),
        .rst    (rst),
        .d      ({in_LATCH, in_SCREEN_CLOCK}),
        .q      (unused_ctl_q),
        .rise_c (ctl_rise)
    );

    hub75_edge_sync #(.WIDTH(DW), .STAGES(SYNC_STAGES), .EDGE(1'b0)) u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .d      ({in_nOE, in_ABCDE, in_RGB1, in_RGB0}),
        .q      (data_s),
        .rise_c (unused_data_rise)
    );

    assign sclk_rise  = ctl_rise[0];
    assign latch_rise = ctl_rise[1];
    assign rgb0_s     = data_s[2:0];
    assign rgb1_s     = data_s[5:3];
    assign abcde_s    = data_s[6 +: ROW_BITS];
    assign noe_s      = data_s[DW-1];

    state_t                   state;
    logic [COLS-1:0][2:0]     sh_top, sh_bot, sh_top_nxt, sh_bot_nxt;
    logic [COLS-1:0][2:0]     hold_top, hold_bot;
    logic [CNT_W-1:0]         col_cnt, cnt_inc;
    logic [IDX_W-1:0]         wr_idx, nxt_idx;
    logic [ROW_BITS-1:0]      row_q, nxt_row;
    logic [CB-1:0]            nxt_col;
    logic                     nxt_bottom, len_bad, accept;
    logic [2:0]               nxt_data;
    logic [CB+ROW_BITS:0]     nxt_addr;

    // Column shift: new pixel enters at the far end, everything moves toward column 0.
    always_comb begin
        sh_top_nxt = sh_top;
        sh_bot_nxt = sh_bot;
        cnt_inc    = col_cnt;
        if (sclk_rise) begin
            for (int unsigned i = 0; i < COLS - 1; i++) begin
                sh_top_nxt[i] = sh_top[i+1];
                sh_bot_nxt[i] = sh_bot[i+1];
            end
            sh_top_nxt[COLS-1] = rgb0_s;
            sh_bot_nxt[COLS-1] = rgb1_s;
            if (col_cnt != CNT_W'(COLS + 1)) cnt_inc = col_cnt + CNT_W'(1);
        end
        len_bad = (cnt_inc != CNT_W'(COLS));
        accept  = latch_rise && (state == ST_IDLE);
    end

    // Next write to present; on an accepted latch it reads the value being captured into hold.
    always_comb begin
        nxt_idx    = (state == ST_IDLE) ? '0 : wr_idx + IDX_W'(1);
        nxt_bottom = (nxt_idx >= IDX_W'(COLS));
        nxt_col    = nxt_bottom ? CB'(nxt_idx - IDX_W'(COLS)) : CB'(nxt_idx);
        nxt_row    = (state == ST_IDLE) ? abcde_s : row_q;
        if (state == ST_IDLE) nxt_data = nxt_bottom ? sh_bot_nxt[nxt_col] : sh_top_nxt[nxt_col];
        else                  nxt_data = nxt_bottom ? hold_bot[nxt_col]   : hold_top[nxt_col];
        nxt_addr = {(nxt_bottom ? HALF_BOTTOM : HALF_TOP), nxt_row, nxt_col};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sh_top      <= '0;
            sh_bot      <= '0;
            hold_top    <= '0;
            hold_bot    <= '0;
            col_cnt     <= '0;
            wr_idx      <= '0;
            row_q       <= '0;
            fb.wr_en    <= 1'b0;
            fb.wr_addr  <= '0;
            fb.wr_data  <= '0;
            fb.row_done <= 1'b0;
            out_BUSY    <= 1'b0;
            out_LIT     <= 1'b0;
            out_LEN_ERR <= 1'b0;
            out_OVERRUN <= 1'b0;
        end else begin
            sh_top      <= sh_top_nxt;
            sh_bot      <= sh_bot_nxt;
            col_cnt     <= accept ? '0 : cnt_inc;
            out_LIT     <= ~noe_s;
            out_LEN_ERR <= 1'b0;
            out_OVERRUN <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (latch_rise) begin
                        hold_top    <= sh_top_nxt;
                        hold_bot    <= sh_bot_nxt;
                        row_q       <= abcde_s;
                        out_LEN_ERR <= len_bad;
                        state       <= ST_COMMIT;
                        out_BUSY    <= 1'b1;
                        wr_idx      <= nxt_idx;
                        fb.wr_en    <= 1'b1;
                        fb.wr_addr  <= nxt_addr;
                        fb.wr_data  <= nxt_data;
                        fb.row_done <= (nxt_idx == LAST);
                    end
                end
                ST_COMMIT: begin
                    // A latch during a commit is dropped; hold and col_cnt stay as they are.
                    out_OVERRUN <= latch_rise;
                    if (wr_idx == LAST) begin
                        state       <= ST_IDLE;
                        out_BUSY    <= 1'b0;
                        fb.wr_en    <= 1'b0;
                        fb.wr_addr  <= '0;
                        fb.wr_data  <= '0;
                        fb.row_done <= 1'b0;
                    end else begin
                        wr_idx      <= nxt_idx;
                        fb.wr_en    <= 1'b1;
                        fb.wr_addr  <= nxt_addr;
                        fb.wr_data  <= nxt_data;
                        fb.row_done <= (nxt_idx == LAST);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HUB75_RX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_LATCH_CNT   <= '0;
            out_LEN_ERR_CNT <= '0;
            out_OVERRUN_CNT <= '0;
        end else begin
            if (accept) out_LATCH_CNT <= out_LATCH_CNT + 16'd1;
            if (accept && len_bad && out_LEN_ERR_CNT != 8'hFF)
                out_LEN_ERR_CNT <= out_LEN_ERR_CNT + 8'd1;
            if (latch_rise && state == ST_COMMIT && out_OVERRUN_CNT != 8'hFF)
                out_OVERRUN_CNT <= out_OVERRUN_CNT + 8'd1;
        end
    end
`endif

endmodule
